// File: rtl/sram_arb_pkg.sv
// Shared constants and helpers for the 128-bit SRAM round-robin arbiter.
package sram_arb_pkg;
   localparam int DATA_W    = 128;
   localparam int STRB_W    = 16;
   localparam int RSP_DEPTH = 2;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [STRB_W-1:0] strb_t;

   // True when at most one bit of v is set.
   function automatic logic onehot0(input logic [31:0] v);
      return (v & (v - 32'd1)) == 32'd0;
   endfunction
endpackage

// File: rtl/sram_rsp_fifo2.sv
// Two-entry in-order read-response buffer; head is presented while occ is non-zero.
module sram_rsp_fifo2
   import sram_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_push,
   input  logic        i_pop,
   input  data_t       i_data,
   output logic [1:0]  o_occ,
   output data_t       o_head
);
   data_t      r_mem [RSP_DEPTH];
   logic       r_wptr;
   logic       r_rptr;
   logic [1:0] r_occ;

   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= 1'b0;
         r_rptr <= 1'b0;
         r_occ  <= 2'd0;
      end else begin
         if (i_push) begin
            r_wptr <= ~r_wptr;
         end
         if (i_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({i_push, i_pop})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_occ  = r_occ;
   assign o_head = r_mem[r_rptr];

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_push && !i_pop && (r_occ == 2'(RSP_DEPTH))));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_pop && (r_occ == 2'd0)));
endmodule

// File: rtl/sram_128b_arb.sv
// Round-robin arbiter sharing one 128-bit single-port SRAM among NUM_REQ ports,
// with a credit-checked 2-entry read-response buffer per port.
module sram_128b_arb
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 15,
   parameter int DEPTH   = 24576
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ-1:0]          req_wen,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   input  logic [NUM_REQ*STRB_W-1:0]   req_wstrb,
   output logic [NUM_REQ-1:0]          rsp_valid,
   input  logic [NUM_REQ-1:0]          rsp_ready,
   output logic [NUM_REQ*DATA_W-1:0]   rsp_rdata,
   output logic                        sram_cen,
   output logic                        sram_wen,
   output logic [ADDR_W-1:0]           sram_addr,
   output logic [DATA_W-1:0]           sram_wdata,
   output logic [STRB_W-1:0]           sram_wstrb,
   input  logic [DATA_W-1:0]           sram_rdata
);
   localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

   logic [PTR_W-1:0]   r_rr_ptr;
   logic [NUM_REQ-1:0] r_inflight;

   logic [PTR_W-1:0]   w_gidx;
   logic [PTR_W-1:0]   w_rr_next;
   logic [PTR_W:0]     w_sum;
   logic               w_any;
   logic [NUM_REQ-1:0] w_grant;
   logic [NUM_REQ-1:0] w_elig;
   logic [NUM_REQ-1:0] w_credit;
   logic [NUM_REQ-1:0] w_pop;
   logic [NUM_REQ-1:0] w_rsp_valid;
   logic [1:0]         w_occ   [NUM_REQ];
   logic [ADDR_W-1:0]  w_addr  [NUM_REQ];
   data_t              w_wdata [NUM_REQ];
   strb_t              w_wstrb [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
      assign w_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
      assign w_wstrb[gi] = req_wstrb[gi*STRB_W +: STRB_W];

      assign w_rsp_valid[gi] = (w_occ[gi] != 2'd0);
      assign w_pop[gi]       = w_rsp_valid[gi] & rsp_ready[gi];
      // Reads already committed (buffered + in the SRAM pipe) less this cycle's pop.
      assign w_credit[gi]    = ({1'b0, w_occ[gi]} + {2'b00, r_inflight[gi]}
                                - {2'b00, w_pop[gi]}) < 3'(RSP_DEPTH);
      // rst_n gating keeps grants and SRAM enable low for the whole reset window.
      assign w_elig[gi]      = rst_n & req_valid[gi] & (req_wen[gi] | w_credit[gi]);

      sram_rsp_fifo2 u_fifo (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_push (r_inflight[gi]),
         .i_pop  (w_pop[gi]),
         .i_data (sram_rdata),
         .o_occ  (w_occ[gi]),
         .o_head (rsp_rdata[gi*DATA_W +: DATA_W])
      );
   end

   always_comb begin
      w_grant = '0;
      w_gidx  = '0;
      w_any   = 1'b0;
      w_sum   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
         if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
         end
         if (!w_any && w_elig[w_sum[PTR_W-1:0]]) begin
            w_any  = 1'b1;
            w_gidx = w_sum[PTR_W-1:0];
         end
      end
      if (w_any) begin
         w_grant[w_gidx] = 1'b1;
      end
   end

   assign w_rr_next = (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + PTR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr   <= '0;
         r_inflight <= '0;
      end else begin
         if (w_any) begin
            r_rr_ptr <= w_rr_next;
         end
         r_inflight <= w_grant & ~req_wen;
      end
   end

   assign req_ready  = w_grant;
   assign rsp_valid  = w_rsp_valid;
   assign sram_cen   = w_any;
   assign sram_wen   = w_any & req_wen[w_gidx];
   assign sram_addr  = w_addr[w_gidx];
   assign sram_wdata = w_wdata[w_gidx];
   assign sram_wstrb = w_wstrb[w_gidx];

   a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      onehot0(32'(req_ready)));
   a_ready_has_valid: assert property (@(posedge clk) disable iff (!rst_n)
      (req_ready & ~req_valid) == '0);
   a_addr_in_depth: assert property (@(posedge clk) disable iff (!rst_n)
      sram_cen |-> (int'(sram_addr) < DEPTH));
endmodule

// File: tb/tb_sram_128b_arb.sv
// Bench for sram_128b_arb: SRAM macro model, per-cycle scoreboard and directed scenarios.
`timescale 1ns/1ps
module tb_sram_128b_arb;
   localparam int N     = 2;
   localparam int AW    = 15;
   localparam int DEPTH = 24576;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]     req_valid, req_ready, req_wen, rsp_valid, rsp_ready;
   logic [N*AW-1:0]  req_addr;
   logic [N*128-1:0] req_wdata, rsp_rdata;
   logic [N*16-1:0]  req_wstrb;
   logic             sram_cen, sram_wen;
   logic [AW-1:0]    sram_addr;
   logic [127:0]     sram_wdata, sram_rdata;
   logic [15:0]      sram_wstrb;

   logic          t_valid [N];
   logic          t_wen   [N];
   logic          t_rdy   [N];
   logic [AW-1:0] t_addr  [N];
   logic [127:0]  t_wdata [N];
   logic [15:0]   t_wstrb [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_drv
      assign req_valid[gi]              = t_valid[gi];
      assign req_wen[gi]                = t_wen[gi];
      assign rsp_ready[gi]              = t_rdy[gi];
      assign req_addr[gi*AW +: AW]      = t_addr[gi];
      assign req_wdata[gi*128 +: 128]   = t_wdata[gi];
      assign req_wstrb[gi*16 +: 16]     = t_wstrb[gi];
   end

   sram_128b_arb #(.NUM_REQ(N), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wen    (req_wen),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .sram_cen   (sram_cen),
      .sram_wen   (sram_wen),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_wstrb (sram_wstrb),
      .sram_rdata (sram_rdata)
   );

   function automatic logic [127:0] merge(input logic [127:0] d, input logic [15:0] s);
      logic [127:0] r;
      r = '0;
      for (int b = 0; b < 16; b++) begin
         if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
      end
      return r;
   endfunction

   function automatic logic [127:0] pat(input int a);
      return {4{32'hC0DE0000 | 32'(a)}};
   endfunction

   // SRAM macro: 1-cycle read latency, rdata changes every clock.
   bit [127:0] macro_mem [DEPTH];
   always @(posedge clk) begin
      if (sram_cen && sram_wen) macro_mem[sram_addr] <= merge(sram_wdata, sram_wstrb);
      sram_rdata <= (sram_cen && !sram_wen) ? macro_mem[sram_addr]
                                            : {$urandom, $urandom, $urandom, $urandom};
   end

   int n_chk = 0;
   int n_pass = 0;
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct { int cyc; logic [127:0] d; } ev_t;
   typedef struct { int port; int cyc; } acc_t;
   ev_t  exp_q   [N][$];
   ev_t  rsp_log [N][$];
   acc_t acc_log [$];
   bit [127:0] ref_mem [DEPTH];

   int cyc = 0;
   int m_rr = 0;
   int m_g, m_p, m_idx;
   logic [N-1:0] m_ev, m_pop, m_elig, m_er;
   logic [AW-1:0] m_a;
   ev_t m_e;

   // Reference model: outstanding reads per port are a queue of {ready cycle, data}.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            for (int i = 0; i < N; i++) exp_q[i].delete();
            m_rr = 0;
            chk("rst_req_ready", req_ready, '0);
            chk("rst_cen", sram_cen, 0);
            chk("rst_rsp_valid", rsp_valid, '0);
         end else begin
            for (int i = 0; i < N; i++) begin
               m_ev[i]   = (exp_q[i].size() > 0) && (exp_q[i][0].cyc <= cyc);
               m_pop[i]  = m_ev[i] && rsp_ready[i];
               m_elig[i] = req_valid[i] &&
                           (req_wen[i] || ((exp_q[i].size() - int'(m_pop[i])) < 2));
            end
            m_g = -1;
            for (int k = 0; k < N; k++) begin
               m_idx = (m_rr + k) % N;
               if (m_g < 0 && m_elig[m_idx]) m_g = m_idx;
            end
            m_er = '0;
            if (m_g >= 0) m_er[m_g] = 1'b1;
            m_p = (m_g >= 0) ? m_g : 0;

            chk("rsp_valid", rsp_valid, m_ev);
            for (int i = 0; i < N; i++) begin
               if (m_ev[i]) chk("rsp_rdata", rsp_rdata[i*128 +: 128], exp_q[i][0].d);
            end
            chk("req_ready", req_ready, m_er);
            chk("sram_cen", sram_cen, (m_g >= 0));
            chk("sram_wen", sram_wen, (m_g >= 0) && req_wen[m_p]);
            chk("sram_addr", sram_addr, req_addr[m_p*AW +: AW]);
            chk("sram_wdata", sram_wdata, req_wdata[m_p*128 +: 128]);
            chk("sram_wstrb", sram_wstrb, req_wstrb[m_p*16 +: 16]);
            if (sram_cen) chk("addr_in_depth", (int'(sram_addr) < DEPTH), 1);

            for (int i = 0; i < N; i++) begin
               if (rsp_valid[i] && rsp_ready[i]) begin
                  rsp_log[i].push_back('{cyc, rsp_rdata[i*128 +: 128]});
                  $display("cyc %0d rsp  port%0d data %h", cyc, i, rsp_rdata[i*128 +: 128]);
               end
               if (req_valid[i] && req_ready[i]) begin
                  acc_log.push_back('{i, cyc});
                  $display("cyc %0d acc  port%0d %s addr %0d", cyc, i,
                           req_wen[i] ? "wr" : "rd", req_addr[i*AW +: AW]);
               end
               if (m_pop[i]) m_e = exp_q[i].pop_front();
            end
            if (m_g >= 0) begin
               m_a = req_addr[m_g*AW +: AW];
               if (req_wen[m_g]) ref_mem[m_a] = merge(req_wdata[m_g*128 +: 128],
                                                      req_wstrb[m_g*16 +: 16]);
               else exp_q[m_g].push_back('{cyc + 2, ref_mem[m_a]});
               m_rr = (m_g + 1) % N;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input int p, input logic w, input int a,
                         input logic [127:0] d, input logic [15:0] s);
      logic hs;
      hs = 1'b0;
      t_valid[p] = 1'b1; t_wen[p] = w; t_addr[p] = AW'(a);
      t_wdata[p] = d;    t_wstrb[p] = s;
      for (int k = 0; k < 20 && !hs; k++) begin
         @(negedge clk);
         hs = req_ready[p];
         step();
      end
      t_valid[p] = 1'b0;
      chk("req_handshake", hs, 1);
   endtask

   task automatic wait_rsp(input int p, input int n, input string name);
      int k;
      k = 0;
      while (rsp_log[p].size() < n && k < 40) begin
         step();
         k++;
      end
      chk(name, (rsp_log[p].size() >= n), 1);
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int n0, na, rd_cyc, idx;
   logic [N-1:0] last_r;

   initial begin
      for (int i = 0; i < N; i++) begin
         t_valid[i] = 0; t_wen[i] = 0; t_addr[i] = '0;
         t_wdata[i] = '0; t_wstrb[i] = '0; t_rdy[i] = 1;
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Full-strobe write then read on port 0: data back exactly 2 cycles after accept.
      do_req(0, 1, 5, 128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF);
      n0 = rsp_log[0].size();
      do_req(0, 0, 5, '0, '0);
      rd_cyc = acc_log[acc_log.size()-1].cyc;
      wait_rsp(0, n0 + 1, "t1_rsp_seen");
      chk("t1_rdata", rsp_log[0][n0].d, 128'h0123456789ABCDEF0123456789ABCDEF);
      chk("t1_latency", rsp_log[0][n0].cyc - rd_cyc, 2);

      // Partial strobe on port 1: unstrobed bytes read back as zero.
      do_req(1, 1, 9, {128{1'b1}}, 16'h000F);
      n0 = rsp_log[1].size();
      do_req(1, 0, 9, '0, '0);
      wait_rsp(1, n0 + 1, "t2_rsp_seen");
      chk("t2_rdata", rsp_log[1][n0].d, 128'h0000000000000000_00000000FFFFFFFF);

      // Contention: both ports write every cycle after reset -> 0,1,0,1.
      reset_dut();
      na = acc_log.size();
      for (int i = 0; i < N; i++) begin
         t_valid[i] = 1; t_wen[i] = 1; t_addr[i] = AW'(100 + i);
         t_wdata[i] = pat(100 + i); t_wstrb[i] = 16'hFFFF;
      end
      repeat (4) step();
      for (int i = 0; i < N; i++) t_valid[i] = 0;
      chk("t3_grant_count", acc_log.size() - na, 4);
      for (int k = 0; k < 4; k++) chk("t3_grant_order", acc_log[na + k].port, k % 2);

      // Backpressure: port 0 reads with rsp_ready low, port 1 keeps writing.
      for (int a = 20; a < 24; a++) do_req(0, 1, a, pat(a), 16'hFFFF);
      t_rdy[0] = 0;
      n0 = rsp_log[0].size();
      idx = 0;
      t_valid[0] = 1; t_wen[0] = 0; t_addr[0] = AW'(20);
      t_valid[1] = 1; t_wen[1] = 1; t_addr[1] = AW'(200);
      t_wdata[1] = pat(200); t_wstrb[1] = 16'hFFFF;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (req_ready[0]) idx++;
         last_r = req_ready;
         step();
         t_addr[0] = AW'(20 + idx);
      end
      chk("t4_accepted_blocked", idx, 2);
      chk("t4_last_grant_p1", last_r, 2'b10);
      t_valid[1] = 0;
      t_rdy[0] = 1;
      for (int k = 0; k < 20 && idx < 4; k++) begin
         @(negedge clk);
         if (req_ready[0]) idx++;
         step();
         t_addr[0] = AW'(20 + idx);
      end
      t_valid[0] = 0;
      chk("t4_accepted_total", idx, 4);
      wait_rsp(0, n0 + 4, "t4_rsp_seen");
      for (int k = 0; k < 4; k++) chk("t4_rdata_order", rsp_log[0][n0 + k].d, pat(20 + k));

      // Streaming: 16 reads accepted and returned on consecutive cycles.
      for (int a = 0; a < 16; a++) do_req(0, 1, a, pat(a), 16'hFFFF);
      na = acc_log.size();
      n0 = rsp_log[0].size();
      idx = 0;
      t_valid[0] = 1; t_wen[0] = 0; t_addr[0] = '0;
      for (int k = 0; k < 40 && idx < 16; k++) begin
         @(negedge clk);
         if (req_ready[0]) idx++;
         step();
         t_addr[0] = AW'(idx);
      end
      t_valid[0] = 0;
      chk("t5_accepts", idx, 16);
      chk("t5_accept_span", acc_log[na + 15].cyc - acc_log[na].cyc, 15);
      wait_rsp(0, n0 + 16, "t5_rsp_seen");
      chk("t5_rsp_span", rsp_log[0][n0 + 15].cyc - rsp_log[0][n0].cyc, 15);
      for (int k = 0; k < 16; k++) chk("t5_rdata", rsp_log[0][n0 + k].d, pat(k));

      // Reset with one buffered response and one read in flight.
      t_rdy[0] = 0;
      do_req(0, 0, 0, '0, '0);
      do_req(0, 0, 1, '0, '0);
      t_valid[1] = 1; t_wen[1] = 1; t_addr[1] = AW'(300);
      t_wdata[1] = pat(300); t_wstrb[1] = 16'hFFFF;
      #2;
      chk("t6_pre_rsp_valid", rsp_valid[0], 1);
      chk("t6_pre_cen", sram_cen, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_rsp_valid", rsp_valid, '0);
      chk("t6_rst_cen", sram_cen, 0);
      chk("t6_rst_req_ready", req_ready, '0);
      t_valid[1] = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      t_rdy[0] = 1;
      n0 = rsp_log[0].size();
      na = acc_log.size();
      for (int i = 0; i < N; i++) begin
         t_valid[i] = 1; t_wen[i] = 1; t_addr[i] = AW'(400 + i);
         t_wdata[i] = pat(400 + i); t_wstrb[i] = 16'hFFFF;
      end
      step();
      for (int i = 0; i < N; i++) t_valid[i] = 0;
      chk("t6_first_grant_count", acc_log.size() - na, 1);
      chk("t6_first_grant_port", acc_log[na].port, 0);
      repeat (6) step();
      chk("t6_no_stale_rsp", rsp_log[0].size() - n0, 0);

      repeat (2) step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/sram_128b_arb.md
Name: sram_128b_arb

Overview:
- Round-robin arbiter that shares one 128-bit single-port SRAM macro between NUM_REQ requesters, e.g. iDMA write-in and read-out engines on the iNoC side.
- Each requester has a valid/ready request channel (read or write) and a valid/ready read-response channel.
- Each port has a 2-entry response buffer, so reads are never lost under response backpressure.
- Drives the SRAM cen/wen/addr/wdata/wstrb pins combinationally from the grant. The SRAM has 1-cycle read latency and its rdata updates every clock.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 15, SRAM word-address width.
- DEPTH, 24576, SRAM depth in 128-bit words. Informational; checked by the bench only.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  request valid per port
- req_ready  out  NUM_REQ  request accepted (grant), combinational
- req_wen  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  word address, port i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*128  write data
- req_wstrb  in  NUM_REQ*16  byte strobes
- rsp_valid  out  NUM_REQ  read data valid
- rsp_ready  in  NUM_REQ  read data accepted
- rsp_rdata  out  NUM_REQ*128  read data
- sram_cen  out  1  SRAM enable
- sram_wen  out  1  SRAM write
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  128  SRAM write data
- sram_wstrb  out  16  SRAM byte strobes
- sram_rdata  in  128  SRAM read data

Behaviour:
- Reset (async, rst_n=0):
  - rr_ptr=0; all inflight flags cleared; all response FIFOs emptied.
  - rsp_valid=0, req_ready=0, sram_cen=0, sram_wen=0.
  - Any inflight read is discarded.
- Eligibility of port i:
  - req_valid[i] & (req_wen[i] | credit_ok[i]).
  - credit_ok[i] = (occ[i] + inflight[i] - pop[i]) < 2.
  - pop[i] = rsp_valid[i] & rsp_ready[i].
- Arbitration:
  - Grant the first eligible port searching from rr_ptr upward, with wrap at NUM_REQ.
  - At most one grant per cycle. req_ready is one-hot or zero.
  - On a grant, rr_ptr <= granted+1, wrapping at NUM_REQ to 0. With no grant, rr_ptr holds.
- SRAM drive, combinational in the grant cycle t:
  - sram_cen=1; sram_wen=req_wen[g]; addr/wdata/wstrb muxed from port g.
  - With no grant: cen=0, wen=0; addr/wdata/wstrb = port 0 values. Don't-care, kept deterministic.
- Writes: complete at the end of cycle t. No response is generated. Unstrobed bytes are written as zero by the macro; the arbiter does not merge.
- Reads:
  - inflight[g] set for cycle t+1.
  - In t+1, sram_rdata is pushed into FIFO g; inflight clears.
  - rsp_valid[g] is asserted at earliest in t+2. Fixed minimum latency is 2 cycles; there is no bypass.
- Response FIFO per port:
  - 2 entries, in order; rsp_rdata = head.
  - Simultaneous push and pop with occ=2 is impossible by credit. Push and pop with occ=1 keeps occ=1.
- Throughput: a single port with rsp_ready=1 sustains 1 read per cycle. Writes are never blocked by response state.
- Simultaneous events: the credit check uses the same-cycle pop. A write and a read from different ports in the same cycle are arbitrated like any other requests.
- Assertions:
  - FIFO overflow never occurs.
  - req_ready is one-hot0.
  - req_ready[i] implies req_valid[i].

Decomposition:
- Package sram_arb_pkg holds DATA_W=128, STRB_W=16, RSP_DEPTH=2, and the onehot0 check function.
- Sub-module sram_rsp_fifo2: 2-entry FIFO with push/pop/occ/head outputs, instantiated NUM_REQ times.

Test Plan:
- Write then read, single port: port0 writes addr 5, wdata 0x0123...CDEF, wstrb 0xFFFF, then reads addr 5 -> rsp_valid[0] exactly 2 cycles after the read handshake, rdata = 0x0123...CDEF.
- Partial strobe: port1 writes addr 9, wdata all 0xFF, wstrb 0x000F, then reads addr 9 -> rdata = 0x000...0FFFFFFFF.
- Contention: NUM_REQ=2, both ports valid every cycle (writes) -> grants alternate 0,1,0,1; first grant goes to port 0 after reset.
- Backpressure: port0 rsp_ready=0, 4 back-to-back reads -> exactly 2 accepted, req_ready[0]=0 afterwards while port1 writes still granted; raise rsp_ready -> remaining 2 accepted, 4 responses in address order.
- Streaming: port0 reads addr 0..15 with rsp_ready=1 -> 16 accepts in 16 consecutive cycles, 16 responses in order with no gaps.
- Reset mid-operation: rst_n low with one inflight read and 1 buffered response -> rsp_valid=0 and sram_cen=0 immediately (asynchronously); after release, the first grant goes to port 0 and no stale response appears.
